// File: rtl/ad9361x2_tdd_pkg.sv
// Shared types and constants for the dual-AD9361 TDD sync generator.
// State encoding, default widths and the shortest legal frame length.
package ad9361x2_tdd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } tdd_state_e;

    localparam int DEF_CNT_WIDTH       = 32;
    localparam int DEF_PULSE_WIDTH_BITS = 16;
    localparam int DEF_FRAME_CNT_WIDTH = 16;

    // A one-cycle frame cannot hold both a pulse edge and a gap.
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/tdd_window_cmp.sv
// On/off window compare against the frame counter.
// Handles empty windows and windows that wrap across the frame end.
module tdd_window_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] on,
    input  logic [WIDTH-1:0] off,
    input  logic [WIDTH-1:0] cnt,
    output logic             active
);

    // Plain window, empty window, or wrapped window depending on on/off order.
    always_comb begin
        active = 1'b0;
        if (on < off) begin
            active = (cnt >= on) && (cnt < off);
        end else if (on > off) begin
            active = (cnt >= on) || (cnt < off);
        end
    end

endmodule

// File: rtl/ad9361x2_tdd_sync_gen.sv
// Frame timing generator feeding the dual-AD9361 wrapper: sync pulse,
// ENABLE/TXNRX levels, double-buffered config and optional ext alignment.
module ad9361x2_tdd_sync_gen
    import ad9361x2_tdd_pkg::*;
#(
    parameter int CNT_WIDTH        = DEF_CNT_WIDTH,
    parameter int PULSE_WIDTH_BITS = DEF_PULSE_WIDTH_BITS,
    parameter int FRAME_CNT_WIDTH  = DEF_FRAME_CNT_WIDTH
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic                        cfg_enable,
    input  logic                        cfg_ext_sync,
    input  logic                        cfg_resync,
    input  logic [CNT_WIDTH-1:0]        cfg_period,
    input  logic [PULSE_WIDTH_BITS-1:0] cfg_pulse_width,
    input  logic [CNT_WIDTH-1:0]        cfg_rx_on,
    input  logic [CNT_WIDTH-1:0]        cfg_rx_off,
    input  logic [CNT_WIDTH-1:0]        cfg_tx_on,
    input  logic [CNT_WIDTH-1:0]        cfg_tx_off,
    input  logic                        ext_sync_i,
    output logic                        sync_out,
    output logic                        up_enable,
    output logic                        up_txnrx,
    output logic [FRAME_CNT_WIDTH-1:0]  frame_count,
    output logic                        busy
);

    localparam int CMP_W = (CNT_WIDTH > PULSE_WIDTH_BITS) ?
                           CNT_WIDTH : PULSE_WIDTH_BITS;
    localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

    tdd_state_e state;
    tdd_state_e state_next;

    logic [CNT_WIDTH-1:0]        counter;
    logic [FRAME_CNT_WIDTH-1:0]  fc_q;

    logic [CNT_WIDTH-1:0]        period_q;
    logic [PULSE_WIDTH_BITS-1:0] pulse_q;
    logic [CNT_WIDTH-1:0]        rx_on_q;
    logic [CNT_WIDTH-1:0]        rx_off_q;
    logic [CNT_WIDTH-1:0]        tx_on_q;
    logic [CNT_WIDTH-1:0]        tx_off_q;

    logic sync_s1;
    logic sync_s2;
    logic sync_s3;
    logic ext_edge;

    logic [CNT_WIDTH-1:0] period_eff;
    logic                 last_cnt;
    logic                 frame_end;

    logic load_shadow;
    logic cnt_clear;
    logic cnt_inc;
    logic fc_inc;

    logic rx_active;
    logic tx_active;
    logic sync_hit;
    logic run_now;

    logic sync_q;
    logic enable_q;
    logic txnrx_q;

    assign ext_edge   = sync_s2 & ~sync_s3;
    assign period_eff = (period_q < MIN_P) ? MIN_P : period_q;
    assign last_cnt   = (counter == (period_eff - ONE));
    assign frame_end  = last_cnt | (cfg_resync & ext_edge);
    assign run_now    = (state == ST_RUN);
    assign sync_hit   = CMP_W'(counter) < CMP_W'(pulse_q);

    tdd_window_cmp #(
        .WIDTH (CNT_WIDTH)
    ) u_rx_win (
        .on     (rx_on_q),
        .off    (rx_off_q),
        .cnt    (counter),
        .active (rx_active)
    );

    tdd_window_cmp #(
        .WIDTH (CNT_WIDTH)
    ) u_tx_win (
        .on     (tx_on_q),
        .off    (tx_off_q),
        .cnt    (counter),
        .active (tx_active)
    );

    // State register.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; stop is only honoured at a frame end.
    always_comb begin
        state_next  = state;
        load_shadow = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        fc_inc      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (cfg_enable) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                load_shadow = 1'b1;
                cnt_clear   = 1'b1;
                if (!cfg_enable) begin
                    state_next = ST_IDLE;
                end else if (!cfg_ext_sync || ext_edge) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_end) begin
                    cnt_clear   = 1'b1;
                    fc_inc      = 1'b1;
                    load_shadow = 1'b1;
                    if (!cfg_enable) begin
                        state_next = ST_DRAIN;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                cnt_clear  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            sync_s3 <= 1'b0;
        end else begin
            sync_s1 <= ext_sync_i;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    // Frame counter and completed-frame counter.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            counter <= '0;
            fc_q    <= '0;
        end else begin
            if (cnt_clear) begin
                counter <= '0;
            end else if (cnt_inc) begin
                counter <= counter + ONE;
            end
            if (fc_inc) begin
                fc_q <= fc_q + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    // Shadow config, captured while arming and at every frame boundary.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            period_q <= '0;
            pulse_q  <= '0;
            rx_on_q  <= '0;
            rx_off_q <= '0;
            tx_on_q  <= '0;
            tx_off_q <= '0;
        end else if (load_shadow) begin
            period_q <= cfg_period;
            pulse_q  <= cfg_pulse_width;
            rx_on_q  <= cfg_rx_on;
            rx_off_q <= cfg_rx_off;
            tx_on_q  <= cfg_tx_on;
            tx_off_q <= cfg_tx_off;
        end
    end

    // Registered outputs, one cycle behind the counter and low outside RUN.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            sync_q   <= 1'b0;
            enable_q <= 1'b0;
            txnrx_q  <= 1'b0;
        end else begin
            sync_q   <= run_now & sync_hit;
            enable_q <= run_now & (rx_active | tx_active);
            txnrx_q  <= run_now & tx_active;
        end
    end

    assign sync_out    = sync_q;
    assign up_enable   = enable_q;
    assign up_txnrx    = txnrx_q;
    assign frame_count = fc_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ad9361x2_tdd_sync_gen.sv
// Directed bench for ad9361x2_tdd_sync_gen.
// Expected levels are written per cycle from the frame timing by hand.
module tb_ad9361x2_tdd_sync_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_enable = 1'b0;
    logic        cfg_ext_sync = 1'b0;
    logic        cfg_resync = 1'b0;
    logic [31:0] cfg_period = '0;
    logic [15:0] cfg_pulse_width = '0;
    logic [31:0] cfg_rx_on = '0;
    logic [31:0] cfg_rx_off = '0;
    logic [31:0] cfg_tx_on = '0;
    logic [31:0] cfg_tx_off = '0;
    logic        ext_sync_i = 1'b0;
    logic        sync_out;
    logic        up_enable;
    logic        up_txnrx;
    logic [15:0] frame_count;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ad9361x2_tdd_sync_gen dut (
        .axi_aclk        (clk),
        .axi_aresetn     (rstn),
        .cfg_enable      (cfg_enable),
        .cfg_ext_sync    (cfg_ext_sync),
        .cfg_resync      (cfg_resync),
        .cfg_period      (cfg_period),
        .cfg_pulse_width (cfg_pulse_width),
        .cfg_rx_on       (cfg_rx_on),
        .cfg_rx_off      (cfg_rx_off),
        .cfg_tx_on       (cfg_tx_on),
        .cfg_tx_off      (cfg_tx_off),
        .ext_sync_i      (ext_sync_i),
        .sync_out        (sync_out),
        .up_enable       (up_enable),
        .up_txnrx        (up_txnrx),
        .frame_count     (frame_count),
        .busy            (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cfg_enable = 1'b0;
        ext_sync_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic set_cfg(input int per, input int pw,
                           input int rxon, input int rxoff,
                           input int txon, input int txoff,
                           input bit ext, input bit rs);
        cfg_period      = 32'(per);
        cfg_pulse_width = 16'(pw);
        cfg_rx_on       = 32'(rxon);
        cfg_rx_off      = 32'(rxoff);
        cfg_tx_on       = 32'(txon);
        cfg_tx_off      = 32'(txoff);
        cfg_ext_sync    = ext;
        cfg_resync      = rs;
    endtask

    // Release reset and enable; after return the counter is 0 in RUN.
    task automatic start_run();
        rstn = 1'b1;
        cfg_enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({sync_out, up_enable, up_txnrx, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outs got %b exp 0000",
                     {sync_out, up_enable, up_txnrx, busy});
        end
        tests++;
        if (frame_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_fc got %0d exp 0", frame_count);
        end
    endtask

    task automatic test_basic();
        int c;
        logic es, ee, et;
        do_reset();
        set_cfg(10, 2, 1, 4, 5, 9, 1'b0, 1'b0);
        rstn = 1'b1;
        cfg_enable = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy got %b exp 1", busy);
        end
        tick();
        for (int k = 0; k < 30; k++) begin
            tick();
            c  = k % 10;
            es = (c < 2);
            ee = (c >= 1 && c <= 3) || (c >= 5 && c <= 8);
            et = (c >= 5 && c <= 8);
            tests++;
            if (sync_out !== es) begin
                fails++;
                $display("FAIL basic_sync k=%0d got %b exp %b", k, sync_out, es);
            end
            tests++;
            if (up_enable !== ee) begin
                fails++;
                $display("FAIL basic_en k=%0d got %b exp %b", k, up_enable, ee);
            end
            tests++;
            if (up_txnrx !== et) begin
                fails++;
                $display("FAIL basic_txnrx k=%0d got %b exp %b", k, up_txnrx, et);
            end
            tests++;
            if (frame_count !== 16'((k + 1) / 10)) begin
                fails++;
                $display("FAIL basic_fc k=%0d got %0d exp %0d",
                         k, frame_count, (k + 1) / 10);
            end
        end
    endtask

    task automatic test_window_wrap();
        int c;
        logic et;
        do_reset();
        set_cfg(10, 2, 3, 3, 8, 2, 1'b0, 1'b0);
        start_run();
        for (int k = 0; k < 20; k++) begin
            tick();
            c  = k % 10;
            et = (c >= 8) || (c < 2);
            tests++;
            if (up_txnrx !== et) begin
                fails++;
                $display("FAIL wrap_txnrx k=%0d got %b exp %b", k, up_txnrx, et);
            end
            tests++;
            if (up_enable !== et) begin
                fails++;
                $display("FAIL wrap_en k=%0d got %b exp %b", k, up_enable, et);
            end
        end
    endtask

    task automatic test_ext_sync();
        logic es;
        do_reset();
        set_cfg(10, 2, 0, 0, 0, 0, 1'b1, 1'b0);
        rstn = 1'b1;
        cfg_enable = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL arm_busy got %b exp 1", busy);
        end
        cfg_enable = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL arm_abort got %b exp 0", busy);
        end
        cfg_enable = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            tests++;
            if ({sync_out, busy} !== 2'b01) begin
                fails++;
                $display("FAIL arm_wait k=%0d got %b exp 01", k, {sync_out, busy});
            end
        end
        ext_sync_i = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            es = (t >= 4) && (((t - 4) % 10) < 2);
            tests++;
            if (sync_out !== es) begin
                fails++;
                $display("FAIL ext_sync t=%0d got %b exp %b", t, sync_out, es);
            end
            tests++;
            if (frame_count !== 16'(t >= 13)) begin
                fails++;
                $display("FAIL ext_fc t=%0d got %0d exp %0d",
                         t, frame_count, int'(t >= 13));
            end
        end
        ext_sync_i = 1'b0;
    endtask

    task automatic test_resync();
        int efc;
        logic es;
        do_reset();
        set_cfg(10, 2, 0, 0, 0, 0, 1'b0, 1'b1);
        start_run();
        for (int k = 0; k < 27; k++) begin
            tick();
            if (k < 5) efc = 0;
            else if (k < 15) efc = 1;
            else if (k < 25) efc = 2;
            else efc = 3;
            if (k <= 5) es = (k < 2);
            else if (k <= 15) es = ((k - 6) < 2);
            else es = (((k - 16) % 10) < 2);
            tests++;
            if (frame_count !== 16'(efc)) begin
                fails++;
                $display("FAIL resync_fc k=%0d got %0d exp %0d", k, frame_count, efc);
            end
            tests++;
            if (sync_out !== es) begin
                fails++;
                $display("FAIL resync_sync k=%0d got %b exp %b", k, sync_out, es);
            end
            if (k == 2 || k == 12) ext_sync_i = 1'b1;
            if (k == 6 || k == 17) ext_sync_i = 1'b0;
        end
    endtask

    task automatic test_drain();
        int efc;
        logic es;
        logic eb;
        do_reset();
        set_cfg(10, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        start_run();
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k < 9) efc = 0;
            else if (k < 13) efc = 1;
            else if (k < 17) efc = 2;
            else if (k < 21) efc = 3;
            else efc = 4;
            if (k <= 9) es = (k < 2);
            else if (k <= 21) es = (((k - 10) % 4) < 2);
            else es = 1'b0;
            eb = (k <= 21);
            tests++;
            if (frame_count !== 16'(efc)) begin
                fails++;
                $display("FAIL drain_fc k=%0d got %0d exp %0d", k, frame_count, efc);
            end
            tests++;
            if (sync_out !== es) begin
                fails++;
                $display("FAIL drain_sync k=%0d got %b exp %b", k, sync_out, es);
            end
            tests++;
            if (busy !== eb) begin
                fails++;
                $display("FAIL drain_busy k=%0d got %b exp %b", k, busy, eb);
            end
            if (k == 2) cfg_enable = 1'b0;
            if (k == 3) cfg_period = 32'd4;
            if (k == 5) cfg_enable = 1'b1;
            if (k == 18) cfg_enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cfg(10, 2, 0, 5, 0, 0, 1'b0, 1'b0);
        start_run();
        for (int k = 0; k < 12; k++) tick();
        tests++;
        if ({sync_out, up_enable, busy, frame_count} !== {3'b111, 16'd1}) begin
            fails++;
            $display("FAIL mid_pre got s=%b e=%b b=%b fc=%0d exp 1 1 1 1",
                     sync_out, up_enable, busy, frame_count);
        end
        rstn = 1'b0;
        tick();
        tests++;
        if ({sync_out, up_enable, up_txnrx, busy, frame_count} !== 20'd0) begin
            fails++;
            $display("FAIL mid_reset got s=%b e=%b t=%b b=%b fc=%0d exp all 0",
                     sync_out, up_enable, up_txnrx, busy, frame_count);
        end
    endtask

    task automatic test_pulse_bounds();
        do_reset();
        set_cfg(1, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        start_run();
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (sync_out !== logic'(k % 2 == 0)) begin
                fails++;
                $display("FAIL minper_sync k=%0d got %b exp %b",
                         k, sync_out, k % 2 == 0);
            end
            tests++;
            if (frame_count !== 16'((k + 1) / 2)) begin
                fails++;
                $display("FAIL minper_fc k=%0d got %0d exp %0d",
                         k, frame_count, (k + 1) / 2);
            end
        end
        do_reset();
        set_cfg(4, 9, 0, 0, 0, 0, 1'b0, 1'b0);
        start_run();
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if (sync_out !== 1'b1) begin
                fails++;
                $display("FAIL wide_pulse k=%0d got %b exp 1", k, sync_out);
            end
        end
        do_reset();
        set_cfg(4, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        start_run();
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if (sync_out !== 1'b0) begin
                fails++;
                $display("FAIL zero_pulse k=%0d got %b exp 0", k, sync_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window_wrap();
        test_ext_sync();
        test_resync();
        test_drain();
        test_reset_mid();
        test_pulse_bounds();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
